// File: rtl/pf_lanectrl_pause_sync_mlane.sv
// Per-lane HS_IO_CLK_PAUSE resynchroniser with minimum pause width and minimum de-assert gap.
// Define PAUSE_SYNC_FALL_EDGE_EN to retime the pause outputs onto the falling CLK edge.
module pf_lanectrl_pause_sync_mlane #(
  parameter int NUM_LANES   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int MIN_GAP     = 0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE,
  output logic [NUM_LANES-1:0] HS_IO_CLK_PAUSE_SYNC,
  output logic                 PAUSE_ANY,
  output logic [NUM_LANES-1:0] PAUSE_DEFERRED
);

  localparam int CNT_MAX = (MIN_PULSE > MIN_GAP) ? MIN_PULSE : MIN_GAP;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(MIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, STRETCH, FOLLOW, GAP} state_t;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    (* syn_keep = 1 *) logic [SYNC_STAGES-1:0] sync_q;
    logic             s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             pause_q;
    logic             defer_q;

    // Shift chain: bit 0 takes the raw request, the top bit feeds the FSM.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        sync_q <= '0;
      end else begin
        sync_q <= SYNC_STAGES'({sync_q, HS_IO_CLK_PAUSE[g]});
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        state   <= IDLE;
        cnt     <= '0;
        pend    <= 1'b0;
        pause_q <= 1'b0;
        defer_q <= 1'b0;
      end else begin
        defer_q <= 1'b0;
        case (state)
          IDLE: begin
            if (s) begin
              state   <= STRETCH;
              cnt     <= PULSE_LD;
              pause_q <= 1'b1;
            end
          end
          STRETCH: begin
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
            end else if (s) begin
              state <= FOLLOW;
            end else begin
              state   <= (MIN_GAP == 0) ? IDLE : GAP;
              cnt     <= GAP_LD;
              pause_q <= 1'b0;
            end
          end
          FOLLOW: begin
            if (!s) begin
              state   <= (MIN_GAP == 0) ? IDLE : GAP;
              cnt     <= GAP_LD;
              pause_q <= 1'b0;
            end
          end
          GAP: begin
            // Only the first request seen in a gap is reported; later ones merge into it.
            if (s && !pend) begin
              defer_q <= 1'b1;
            end
            if (cnt != '0) begin
              cnt <= cnt - CNT_ONE;
              if (s) begin
                pend <= 1'b1;
              end
            end else begin
              pend <= 1'b0;
              if (pend || s) begin
                state   <= STRETCH;
                cnt     <= PULSE_LD;
                pause_q <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: begin
            state   <= IDLE;
            pause_q <= 1'b0;
          end
        endcase
      end
    end

`ifdef PAUSE_SYNC_FALL_EDGE_EN
    logic pause_n_q;

    always_ff @(negedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        pause_n_q <= 1'b0;
      end else begin
        pause_n_q <= pause_q;
      end
    end

    assign HS_IO_CLK_PAUSE_SYNC[g] = pause_n_q;
`else
    assign HS_IO_CLK_PAUSE_SYNC[g] = pause_q;
`endif
    assign PAUSE_DEFERRED[g] = defer_q;
  end

  assign PAUSE_ANY = |HS_IO_CLK_PAUSE_SYNC;

endmodule

// File: tb/tb_pf_lanectrl_pause_sync_mlane.sv
// Bench for pf_lanectrl_pause_sync_mlane: a 4-lane instance (MIN_PULSE=4, MIN_GAP=3) and a
// 1-lane instance (SYNC_STAGES=1, MIN_PULSE=2, MIN_GAP=0), checked against hand-derived waveforms.
module tb_pf_lanectrl_pause_sync_mlane;
  localparam int NL   = 4;
  localparam int MAXC = 1024;
  localparam int NV   = 9;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [NL-1:0] pause_in;
  logic [NL-1:0] sync_a;
  logic [NL-1:0] def_a;
  logic          any_a;
  logic [0:0]    sync_b;
  logic [0:0]    def_b;
  logic          any_b;

  always #5 CLK = ~CLK;

  pf_lanectrl_pause_sync_mlane #(
    .NUM_LANES(NL), .SYNC_STAGES(2), .MIN_PULSE(4), .MIN_GAP(3)
  ) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .HS_IO_CLK_PAUSE(pause_in),
    .HS_IO_CLK_PAUSE_SYNC(sync_a), .PAUSE_ANY(any_a), .PAUSE_DEFERRED(def_a)
  );

  pf_lanectrl_pause_sync_mlane #(
    .NUM_LANES(1), .SYNC_STAGES(1), .MIN_PULSE(2), .MIN_GAP(0)
  ) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .HS_IO_CLK_PAUSE(pause_in[0:0]),
    .HS_IO_CLK_PAUSE_SYNC(sync_b), .PAUSE_ANY(any_b), .PAUSE_DEFERRED(def_b)
  );

  typedef struct {
    int lane;
    int rise;
    int width;
  } pulse_t;

  // Stimulus: mask gets len1 cycles high at offset 0, then len2 cycles at off2 (off2=0: none).
  // Expected: np pulses at (r0,w0),(r1,w1) relative to the drive cycle; doff = deferred pulse cycle.
  typedef struct {
    logic [3:0] mask;
    int len1;
    int off2;
    int len2;
    int np;
    int r0;
    int w0;
    int r1;
    int w1;
    int doff;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       chk_en = 1'b0;
  logic [3:0] prev = '0;
  int         rise_at [NL];
  logic [3:0] exp_sync [MAXC];
  logic [3:0] exp_def [MAXC];
  pulse_t     sb_q [$];
  vec_t       vt [NV];
  logic [31:0] ca [NL];
  logic [31:0] cany, cdef, cb, cdefb;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle waveform check plus pulse scoreboard for dut_a.
  always @(negedge CLK) begin
    if (chk_en && cyc < MAXC) begin
      chk($sformatf("sync_vec@%0d", cyc), 32'(sync_a), 32'(exp_sync[cyc]));
      chk($sformatf("pause_any@%0d", cyc), 32'(any_a), 32'(|exp_sync[cyc]));
      chk($sformatf("deferred@%0d", cyc), 32'(def_a), 32'(exp_def[cyc]));
      for (int l = 0; l < NL; l++) begin
        if (sync_a[l] && !prev[l]) rise_at[l] = cyc;
        if (!sync_a[l] && prev[l]) begin
          chk($sformatf("sb_pending@%0d", cyc), 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            pulse_t p;
            p = sb_q.pop_front();
            chk($sformatf("sb_lane@%0d", cyc), l, p.lane);
            chk($sformatf("sb_rise@%0d", cyc), rise_at[l], p.rise);
            chk($sformatf("sb_width@%0d", cyc), cyc - rise_at[l], p.width);
          end
        end
      end
    end
    prev = sync_a;
  end

  // Drives one pattern for 30 cycles from a negedge and records every output as a bit word.
  task automatic cap_run(input logic [3:0] mask, input int len1, input int off2, input int len2);
    for (int l = 0; l < NL; l++) ca[l] = '0;
    cany = '0; cdef = '0; cb = '0; cdefb = '0;
    for (int k = 0; k < 30; k++) begin
      pause_in = ((k < len1) || (off2 > 0 && k >= off2 && k < off2 + len2)) ? mask : 4'h0;
      @(negedge CLK);
      for (int l = 0; l < NL; l++) ca[l][k+1] = sync_a[l];
      cany[k+1]  = any_a;
      cdef[k+1]  = |def_a;
      cb[k+1]    = sync_b[0];
      cdefb[k+1] = def_b[0];
    end
  endtask

  initial begin
    int t, r, w;
    for (int i = 0; i < MAXC; i++) begin
      exp_sync[i] = '0;
      exp_def[i]  = '0;
    end
    vt[0] = '{4'b0001, 1, 0, 0, 1, 3, 4, 0, 0, -1};   // 1-cycle request stretched to 4
    vt[1] = '{4'b0010, 10, 0, 0, 1, 3, 10, 0, 0, -1}; // long request followed
    vt[2] = '{4'b0100, 4, 0, 0, 1, 3, 4, 0, 0, -1};   // exactly MIN_PULSE
    vt[3] = '{4'b1000, 5, 0, 0, 1, 3, 5, 0, 0, -1};   // MIN_PULSE+1
    vt[4] = '{4'b0100, 1, 5, 1, 2, 3, 4, 10, 4, 8};   // request deferred by gap
    vt[5] = '{4'b0001, 1, 5, 8, 2, 3, 4, 10, 6, 8};   // long request in gap, one deferral
    vt[6] = '{4'b0010, 1, 2, 1, 1, 3, 4, 0, 0, -1};   // request during stretch absorbed
    vt[7] = '{4'b1001, 2, 0, 0, 1, 3, 4, 0, 0, -1};   // two lanes together
    vt[8] = '{4'b0100, 1, 8, 1, 2, 3, 4, 11, 4, -1};  // request just after gap ends

    RESET_N  = 1'b0;
    pause_in = 4'hF;
    repeat (3) @(negedge CLK);
    chk("rst_sync", 32'(sync_a), 32'h0);
    chk("rst_any", 32'(any_a), 32'h0);
    chk("rst_def", 32'(def_a), 32'h0);
    chk("rst_sync_b", 32'(sync_b), 32'h0);

    RESET_N = 1'b1;
    cap_run(4'hF, 2, 0, 0);
    for (int l = 0; l < NL; l++) chk($sformatf("rel_lane%0d", l), ca[l], 32'h78);
    chk("rel_any", cany, 32'h78);
    chk("rel_b", cb, 32'h0C);

    // Reset while lane 1 is mid-stretch.
    pause_in = 4'b0010;
    @(negedge CLK);
    pause_in = 4'h0;
    repeat (3) @(negedge CLK);
    chk("midrst_pre", 32'(sync_a), 32'h2);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_sync", 32'(sync_a), 32'h0);
    chk("midrst_any", 32'(any_a), 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    cap_run(4'h0, 0, 0, 0);
    chk("midrst_quiet", ca[1], 32'h0);
    chk("midrst_quiet_any", cany, 32'h0);
    cap_run(4'b0010, 1, 0, 0);
    chk("midrst_restart", ca[1], 32'h78);
    chk("midrst_restart_l0", ca[0], 32'h0);
    chk("midrst_restart_def", cdef, 32'h0);

    chk_en = 1'b1;
    for (int v = 0; v < NV; v++) begin
      t = cyc;
      for (int j = 0; j < vt[v].np; j++) begin
        r = (j == 0) ? vt[v].r0 : vt[v].r1;
        w = (j == 0) ? vt[v].w0 : vt[v].w1;
        for (int l = 0; l < NL; l++) begin
          if (vt[v].mask[l]) begin
            sb_q.push_back('{l, t + r, w});
            for (int c = 0; c < w; c++) exp_sync[t + r + c][l] = 1'b1;
          end
        end
      end
      if (vt[v].doff >= 0) exp_def[t + vt[v].doff] = exp_def[t + vt[v].doff] | vt[v].mask;
      for (int k = 0; k < 32; k++) begin
        pause_in = ((k < vt[v].len1) ||
                    (vt[v].off2 > 0 && k >= vt[v].off2 && k < vt[v].off2 + vt[v].len2))
                   ? vt[v].mask : 4'h0;
        @(negedge CLK);
      end
    end
    chk_en = 1'b0;
    chk("sb_drain", sb_q.size(), 32'd0);

    // Single-stage, no-gap instance.
    cap_run(4'b0001, 1, 0, 0);
    chk("b_stretch", cb, 32'h0000_000C);
    chk("b_stretch_def", cdefb, 32'h0);
    chk("a_lane0_stretch", ca[0], 32'h78);
    cap_run(4'b0001, 10, 0, 0);
    chk("b_follow", cb, 32'h0000_0FFC);
    cap_run(4'b0001, 1, 3, 1);
    chk("b_nogap", cb, 32'h0000_006C);
    chk("b_nogap_def", cdefb, 32'h0);
    chk("a_absorb", ca[0], 32'h78);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
